ufo_unpack: RTL

Converts the wide 64-bit fixed-point stream (Q25.39, two's complement) back into the 17-bit signed integer sample format, with round-half-up and saturation. It is the return-direction counterpart of the 17-to-64 expansion stage. Two-stage pipeline with enable/valid qualification and an optional saturation-event counter for datapath monitoring.

---
 rtl/ufo_unpack.sv | 82 ++++++++
 1 files changed

// File: rtl/ufo_unpack.sv
// Q25.39 -> 17-bit signed sample: round-half-up, saturate, 2-stage pipeline.
// Optional saturation-event counter built when UFO_UNPACK_SAT_CNT_EN is defined.
module ufo_unpack #(
    parameter int DATA_WIDTH_IN  = 64,
    parameter int DATA_WIDTH_OUT = 17,
    parameter int FRAC_BITS      = 39,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enb,
    input  logic [DATA_WIDTH_IN-1:0]  i_data,
    input  logic                      i_clr,
    output logic [DATA_WIDTH_OUT-1:0] o_data,
    output logic                      o_valid,
    output logic                      o_sat,
    output logic [CNT_WIDTH-1:0]      o_sat_cnt
);
    localparam int STAGES = 2;
    localparam int SUM_W  = DATA_WIDTH_IN + 1;
    localparam int Q_W    = SUM_W - FRAC_BITS;
    localparam int TOP_W  = Q_W - DATA_WIDTH_OUT + 1;
    localparam logic [SUM_W-1:0] HALF = SUM_W'(1) << (FRAC_BITS - 1);

    logic [STAGES-1:0]         vld_pipe;
    logic [SUM_W-1:0]          sum_d;
    logic [Q_W-1:0]            q_q;
    logic [TOP_W-1:0]          q_top;
    logic                      ovf;
    logic [DATA_WIDTH_OUT-1:0] data_d;
    logic                      unused_frac;

    // Sign-extend by one bit so the rounding bias can never overflow.
    assign sum_d       = {i_data[DATA_WIDTH_IN-1], i_data} + HALF;
    assign unused_frac = ^sum_d[FRAC_BITS-1:0];

    // Only the integer part of the biased sum is needed downstream.
    always_ff @(posedge i_clk) begin
        if (i_enb)
            q_q <= sum_d[SUM_W-1:FRAC_BITS];
    end

    // Out of range when the bits above the output sign are not a pure sign extension.
    assign q_top = q_q[Q_W-1:DATA_WIDTH_OUT-1];
    assign ovf   = !((&q_top) || !(|q_top));

    always_comb begin
        data_d = q_q[DATA_WIDTH_OUT-1:0];
        if (ovf)
            data_d = q_q[Q_W-1] ? {1'b1, {(DATA_WIDTH_OUT-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH_OUT-1){1'b1}}};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe <= '0;
            o_data   <= '0;
            o_sat    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], i_enb};
            o_sat    <= vld_pipe[0] & ovf;
            if (vld_pipe[0])
                o_data <= data_d;
        end
    end

    assign o_valid = vld_pipe[STAGES-1];

`ifdef UFO_UNPACK_SAT_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            o_sat_cnt <= '0;
        else if (o_valid && o_sat && !(&o_sat_cnt))
            o_sat_cnt <= o_sat_cnt + CNT_WIDTH'(1);
    end
`else
    logic unused_clr;
    assign unused_clr = i_clr;
    assign o_sat_cnt  = '0;
`endif

endmodule
